eth_ram_dma_master: RTL and testbench

ETH_RAM_DMA_MASTER -- requirements
Module: eth_ram_dma_master

---
 rtl/eth_ram_dma_master.sv | 279 +++++++++++++++++++++++++++
 tb/tb_eth_ram_dma_master.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_ram_dma_master.sv
// ---------------------------------------------------------------------------
// eth_ram_dma_master
//
// Moves word streams between a 32-bit stream interface and a word-organised
// RAM that sits behind a pipelined Avalon-MM master port.
//
//   write command (cmd_write=1): snk stream  -> RAM, one word per address
//   read  command (cmd_write=0): RAM -> src stream, through a small FIFO
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_write, cmd_addr,        direction, start word address and word count
//   cmd_len                     (cmd_len = 0 completes with no bus traffic)
//   snk_data/valid/ready        write-data stream in
//   src_data/valid/ready        read-data stream out
//   avm_*                       Avalon-MM master (byte addressed, full words)
//   busy                        a transfer is in progress
//   done                        one-cycle pulse when a command has completed
//
// Read flow control: a read may only be launched while the number of reads
// in flight plus the words already parked in the FIFO is below MAX_OUT, so
// every returning word is guaranteed a FIFO slot even if the stream consumer
// stalls indefinitely.
// ---------------------------------------------------------------------------
module eth_ram_dma_master #(
  parameter int ADDR_W  = 11,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  // write-data stream sink
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  // read-data stream source
  output logic [31:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready,
  // Avalon-MM master
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  // status
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CNT_W:0]   MAX_OUT_C = (CNT_W + 1)'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_reg,     state_next;
  logic [ADDR_W-1:0] addr_reg,      addr_next;      // word address on the bus
  logic [ADDR_W:0]   remain_reg,    remain_next;    // words not yet launched
  logic              avm_read_reg,  avm_read_next;
  logic              avm_write_reg, avm_write_next;
  logic [31:0]       wdata_reg,     wdata_next;
  logic              done_reg,      done_next;
  logic [CNT_W-1:0]  out_cnt_reg,   out_cnt_next;   // reads launched, data not back
  logic [CNT_W-1:0]  fifo_cnt_reg,  fifo_cnt_next;  // words parked in the FIFO
  logic [PTR_W-1:0]  wr_ptr_reg,    wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg,    rd_ptr_next;

  logic [31:0]        fifo_mem [MAX_OUT];
  logic [MAX_OUT-1:0] slot_we;

  logic           cmd_fire;
  logic           snk_fire;
  logic           src_fire;
  logic           bus_active;
  logic           bus_accept;
  logic           bus_free;
  logic           rd_push;
  logic           rd_issue;
  logic [CNT_W:0] credits_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Handshake qualifiers
  // -------------------------------------------------------------------------
  assign cmd_ready  = (state_reg == IDLE);
  assign cmd_fire   = cmd_valid & cmd_ready;

  assign bus_active = avm_read_reg | avm_write_reg;
  assign bus_accept = bus_active & ~avm_waitrequest;
  // The command register may be reloaded when it is empty or being consumed
  // this cycle; otherwise it must hold while the slave stalls.
  assign bus_free   = ~bus_active | ~avm_waitrequest;

  assign snk_ready  = (state_reg == WRITE) & bus_free & (remain_reg != '0);
  assign snk_fire   = snk_valid & snk_ready;

  assign src_valid  = (fifo_cnt_reg != '0);
  assign src_data   = fifo_mem[rd_ptr_reg];
  assign src_fire   = src_valid & src_ready;

  // Returning data is only meaningful while a read transfer owns the bus;
  // stragglers from an aborted transfer (or any stray pulse) are dropped.
  assign rd_push    = avm_readdatavalid
                    & ((state_reg == READ) | (state_reg == DRAIN))
                    & (out_cnt_reg != '0);

  assign credits_used = {1'b0, out_cnt_reg} + {1'b0, fifo_cnt_reg};
  assign rd_issue     = (state_reg == READ) & bus_free & (remain_reg != '0)
                      & (credits_used < MAX_OUT_C);

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remain_next    = remain_reg;
    avm_read_next  = avm_read_reg;
    avm_write_next = avm_write_reg;
    wdata_next     = wdata_reg;
    done_next      = 1'b0;

    // The address only advances when the slave takes the current command,
    // so it is naturally stable across waitrequest and wraps at the top.
    if (bus_accept) begin
      addr_next = addr_reg + ADDR_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          addr_next   = cmd_addr;
          remain_next = cmd_len;
          if (cmd_len == '0) begin
            done_next = 1'b1;
          end else if (cmd_write) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end

      WRITE: begin
        if (snk_fire) begin
          avm_write_next = 1'b1;
          wdata_next     = snk_data;
          remain_next    = remain_reg - (ADDR_W + 1)'(1);
        end else if (bus_accept) begin
          avm_write_next = 1'b0;
        end
        // remain_reg counts words still to be taken from the sink, so zero
        // here means the word now leaving was the last one.
        if (bus_accept && (remain_reg == '0)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      READ: begin
        if (rd_issue) begin
          avm_read_next = 1'b1;
          remain_next   = remain_reg - (ADDR_W + 1)'(1);
        end else if (bus_accept) begin
          avm_read_next = 1'b0;
        end
        if (bus_accept && (remain_reg == '0)) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        // Finish once nothing is in flight and the FIFO empties this cycle.
        if ((out_cnt_reg == '0) &&
            ((fifo_cnt_reg == '0) ||
             ((fifo_cnt_reg == CNT_W'(1)) && src_fire))) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Credit and FIFO bookkeeping: launch, return and pop may all coincide.
    out_cnt_next  = out_cnt_reg  + CNT_W'(rd_issue) - CNT_W'(rd_push);
    fifo_cnt_next = fifo_cnt_reg + CNT_W'(rd_push)  - CNT_W'(src_fire);
    wr_ptr_next   = rd_push  ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next   = src_fire ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remain_reg    <= '0;
      avm_read_reg  <= 1'b0;
      avm_write_reg <= 1'b0;
      wdata_reg     <= '0;
      done_reg      <= 1'b0;
      out_cnt_reg   <= '0;
      fifo_cnt_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remain_reg    <= remain_next;
      avm_read_reg  <= avm_read_next;
      avm_write_reg <= avm_write_next;
      wdata_reg     <= wdata_next;
      done_reg      <= done_next;
      out_cnt_reg   <= out_cnt_next;
      fifo_cnt_reg  <= fifo_cnt_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Read-return FIFO storage (one write strobe per slot)
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUT; gi++) begin : g_slot_we
      assign slot_we[gi] = rd_push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (slot_we[i]) begin
          fifo_mem[i] <= avm_readdata;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign avm_address    = {addr_reg, 2'b00};
  assign avm_read       = avm_read_reg;
  assign avm_write      = avm_write_reg;
  assign avm_writedata  = wdata_reg;
  assign avm_byteenable = 4'hF;
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;

endmodule

// File: tb/tb_eth_ram_dma_master.sv
module tb_eth_ram_dma_master;

  localparam int ADDR_W  = 11;
  localparam int MAX_OUT = 4;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic [31:0]       snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic [31:0]       src_data;
  logic              src_valid;
  logic              src_ready;
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic              busy;
  logic              done;

  eth_ram_dma_master #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .snk_data          (snk_data),
    .snk_valid         (snk_valid),
    .snk_ready         (snk_ready),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- RAM image and reference model ----------------
  logic [31:0] mem     [DEPTH];   // contents of the slave RAM
  logic [31:0] exp_mem [DEPTH];   // what the RAM should contain
  logic [31:0] rd_pending[$];     // read data owed by the slave, in order
  logic [31:0] snk_q[$];          // words still to be offered on snk
  logic [31:0] src_log[$];
  logic [31:0] exp_words[$];
  logic [31:0] wr_log_data[$];
  int          wr_log_addr[$];
  int          rd_log_addr[$];

  // environment knobs
  int wait_mode;   // 0 never stall, 1 random stall, 2 stall 3 cycles on 2nd write
  int src_mode;    // 0 src_ready low, 1 high, 2 random
  bit snk_rand;
  bit rdv_rand;
  bit rdv_hold;

  // monitor-owned counters (read by the stimulus through snapshots)
  int cyc = 0, rd_acc = 0, wr_acc = 0, done_cnt = 0, stall_seen = 0;
  int done_cyc = 0, last_wacc_cyc = 0, last_pop_cyc = 0;
  int rd_base, wr_base, done_base, stall_base;
  bit cur_wr;
  int cur_addr, cur_len;

  // ---------------- slave model and protocol monitor ----------------
  int   cr_acc = 0, cr_pop = 0;
  bit   prev_reset = 1'b1, prev_hold = 1'b0;
  logic [ADDR_W+1:0] prev_addr;
  logic [31:0]       prev_wdata;
  logic [1:0]        prev_rw;

  always @(posedge clk) begin
    if (!reset && !prev_reset) begin
      if (avm_read || avm_write)
        check("rw_exclusive", {63'd0, avm_read & avm_write}, 64'd0);
      if (prev_hold) begin
        check("hold_cmd", {62'd0, avm_read, avm_write}, {62'd0, prev_rw});
        check("hold_addr", 64'(avm_address), 64'(prev_addr));
        if (prev_rw[0]) check("hold_wdata", 64'(avm_writedata), 64'(prev_wdata));
      end
      if (avm_read)
        check("credit_limit", 64'((cr_acc - cr_pop + 1) <= MAX_OUT), 64'd1);
    end
    prev_hold  = (avm_read || avm_write) && avm_waitrequest;
    prev_addr  = avm_address;
    prev_wdata = avm_writedata;
    prev_rw    = {avm_read, avm_write};
    prev_reset = reset;

    if (avm_readdatavalid && rd_pending.size() > 0) void'(rd_pending.pop_front());
    if (avm_read && !avm_waitrequest) begin
      rd_pending.push_back(mem[avm_address[ADDR_W+1:2]]);
      rd_log_addr.push_back(int'(avm_address));
      rd_acc <= rd_acc + 1;
    end
    if (avm_write && !avm_waitrequest) begin
      mem[avm_address[ADDR_W+1:2]] = avm_writedata;
      wr_log_addr.push_back(int'(avm_address));
      wr_log_data.push_back(avm_writedata);
      wr_acc        <= wr_acc + 1;
      last_wacc_cyc <= cyc;
    end
    if (avm_write && avm_waitrequest) stall_seen <= stall_seen + 1;
    if (snk_valid && snk_ready) void'(snk_q.pop_front());
    if (src_valid && src_ready) begin
      src_log.push_back(src_data);
      last_pop_cyc <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (reset) begin
      cr_acc = 0;
      cr_pop = 0;
    end else begin
      if (avm_read && !avm_waitrequest) cr_acc++;
      if (src_valid && src_ready) cr_pop++;
    end
    cyc <= cyc + 1;
  end

  // ---------------- input drivers (away from the active edge) ----------------
  always @(negedge clk) begin
    case (wait_mode)
      0: avm_waitrequest = 1'b0;
      1: avm_waitrequest = ($urandom_range(0, 2) == 0);
      default: avm_waitrequest = avm_write && (wr_acc - wr_base == 1) &&
                                 (stall_seen - stall_base < 3);
    endcase
    snk_valid = (snk_q.size() > 0) && (!snk_rand || ($urandom_range(0, 1) == 1));
    snk_data  = (snk_q.size() > 0) ? snk_q[0] : 32'h0;
    case (src_mode)
      0: src_ready = 1'b0;
      1: src_ready = 1'b1;
      default: src_ready = ($urandom_range(0, 1) == 1);
    endcase
    if (!rdv_hold && rd_pending.size() > 0 && (!rdv_rand || ($urandom_range(0, 1) == 1))) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = rd_pending[0];
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_cmd(input bit wr, input int addr, input int len);
    int n;
    int a;
    logic [31:0] w;
    cur_wr = wr; cur_addr = addr; cur_len = len;
    src_log.delete(); wr_log_addr.delete(); wr_log_data.delete(); rd_log_addr.delete();
    exp_words.delete();
    wr_base = wr_acc; rd_base = rd_acc; done_base = done_cnt; stall_base = stall_seen;
    for (int i = 0; i < len; i++) begin
      a = (addr + i) % DEPTH;
      if (wr) begin
        w = $urandom;
        snk_q.push_back(w);
        exp_mem[a] = w;
        exp_words.push_back(w);
      end else begin
        exp_words.push_back(exp_mem[a]);
      end
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = (ADDR_W + 1)'(len);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (len > 0) begin
      check("busy_after_accept", 64'(busy), 64'd1);
      check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    end
  endtask

  task automatic finish_xfer();
    int n;
    int a;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    if (cur_wr) check("writes_at_done", 64'(wr_log_addr.size()), 64'(cur_len));
    else        check("pops_at_done",   64'(src_log.size()),     64'(cur_len));
    @(negedge clk);
    check("done_width", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_count", 64'(done_cnt - done_base), 64'd1);
    if (cur_wr) check("done_lat_write", 64'(done_cyc - last_wacc_cyc), 64'd1);
    else        check("done_lat_pop",   64'(done_cyc - last_pop_cyc),  64'd1);
    if (cur_wr) begin
      for (int i = 0; i < cur_len && i < wr_log_addr.size(); i++) begin
        a = (cur_addr + i) % DEPTH;
        check("wr_addr", 64'(wr_log_addr[i]), 64'(a * 4));
        check("wr_data", 64'(wr_log_data[i]), 64'(exp_words[i]));
        check("ram_word", 64'(mem[a]), 64'(exp_mem[a]));
      end
    end else begin
      check("rd_count", 64'(rd_log_addr.size()), 64'(cur_len));
      for (int i = 0; i < cur_len && i < rd_log_addr.size(); i++)
        check("rd_addr", 64'(rd_log_addr[i]), 64'(((cur_addr + i) % DEPTH) * 4));
      for (int i = 0; i < cur_len && i < src_log.size(); i++)
        check("src_word", 64'(src_log[i]), 64'(exp_words[i]));
    end
    $display("xfer %s addr=%0d len=%0d writes=%0d reads=%0d popped=%0d",
             cur_wr ? "WR" : "RD", cur_addr, cur_len,
             wr_log_addr.size(), rd_log_addr.size(), src_log.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avm_read"},  64'(avm_read),      64'd0);
    check({tag, "_avm_write"}, 64'(avm_write),     64'd0);
    check({tag, "_snk_ready"}, 64'(snk_ready),     64'd0);
    check({tag, "_src_valid"}, 64'(src_valid),     64'd0);
    check({tag, "_done"},      64'(done),          64'd0);
    check({tag, "_busy"},      64'(busy),          64'd0);
    check({tag, "_address"},   64'(avm_address),   64'd0);
    check({tag, "_wdata"},     64'(avm_writedata), 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int len;
    int addr;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      exp_mem[i] = mem[i];
    end
    wait_mode = 0; src_mode = 1; snk_rand = 0; rdv_rand = 0; rdv_hold = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    snk_valid = 1'b0; snk_data = '0; src_ready = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("byteenable", 64'(avm_byteenable), 64'hF);
    reset = 1'b0;
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    // write addr 5, len 3, no stalls
    start_cmd(1'b1, 5, 3);
    finish_xfer();

    // read across the top of memory
    start_cmd(1'b0, 2046, 4);
    finish_xfer();

    // consumer stalled: reads stop at the credit limit, then resume
    src_mode = 0;
    start_cmd(1'b0, 100, 8);
    repeat (20) @(negedge clk);
    check("reads_at_credit_limit", 64'(rd_acc - rd_base), 64'(MAX_OUT));
    check("avm_read_throttled", 64'(avm_read), 64'd0);
    check("src_valid_stalled", 64'(src_valid), 64'd1);
    src_mode = 1;
    finish_xfer();

    // waitrequest held for 3 cycles on the second write
    wait_mode = 2;
    start_cmd(1'b1, 300, 4);
    finish_xfer();
    check("stall_cycles", 64'(stall_seen - stall_base), 64'd3);
    wait_mode = 0;

    // zero-length command
    start_cmd(1'b0, 7, 0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_no_bus", {62'd0, avm_read, avm_write}, 64'd0);
    @(negedge clk);
    check("len0_done_width", 64'(done), 64'd0);
    check("len0_no_reads", 64'(rd_acc - rd_base), 64'd0);
    check("len0_no_writes", 64'(wr_acc - wr_base), 64'd0);
    $display("xfer RD addr=7 len=0 done_pulses=%0d", done_cnt - done_base);

    // reset mid-read with reads outstanding; late data must be dropped
    rdv_hold = 1;
    start_cmd(1'b0, 500, 8);
    n = 0;
    while ((rd_acc - rd_base) < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("outstanding_before_reset", 64'((rd_acc - rd_base) >= 2), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    check("cmd_ready_post_abort", 64'(cmd_ready), 64'd1);
    rdv_hold = 0;
    n = 0;
    while (rd_pending.size() > 0 && n < 50) begin
      @(negedge clk);
      check("late_data_ignored", 64'(src_valid), 64'd0);
      n++;
    end
    check("late_data_drained", 64'(rd_pending.size()), 64'd0);
    @(negedge clk);
    check("late_data_ignored_end", 64'(src_valid), 64'd0);
    $display("xfer RD addr=500 len=8 aborted by reset");
    start_cmd(1'b0, 2040, 12);
    finish_xfer();

    // randomized transfers
    for (int t = 0; t < 14; t++) begin
      wait_mode = $urandom_range(0, 1);
      src_mode  = $urandom_range(1, 2);
      snk_rand  = 1'($urandom_range(0, 1));
      rdv_rand  = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 24);
      addr = ($urandom_range(0, 1) == 1) ? $urandom_range(DEPTH - 16, DEPTH - 1)
                                         : $urandom_range(0, DEPTH - 1);
      start_cmd(1'($urandom_range(0, 1)), addr, len);
      finish_xfer();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
